// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access stage: control-bit positions and FSM states.
// Pure declarations; no timing or flow-control behaviour of its own.
package mem_stage_pkg;

    localparam int WB_W = 2;
    localparam int M_W  = 3;

    localparam int WB_REGWRITE = 0;
    localparam int WB_MEMTOREG = 1;

    localparam int M_MEMWRITE = 0;
    localparam int M_MEMREAD  = 1;
    localparam int M_BRANCH   = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mem_state_e;

    function automatic logic is_memop(input logic [M_W-1:0] m);
        return m[M_MEMREAD] | m[M_MEMWRITE];
    endfunction

    // A combined read+write request is a store; it must never produce load data.
    function automatic logic is_load(input logic [M_W-1:0] m);
        return m[M_MEMREAD] & ~m[M_MEMWRITE];
    endfunction

endpackage

// File: rtl/mem_stage_ram.sv
// Word-addressed data RAM: synchronous write, combinational read.
// Read is zero-latency; no backpressure, the write enable is the only control.
module data_ram #(
    parameter int DEPTH_WORDS = 256,
    parameter int ADDR_W      = $clog2(DEPTH_WORDS)
) (
    input  logic              clock,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [31:0] mem_q [DEPTH_WORDS];

    always_ff @(posedge clock) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
    end

    assign rdata = mem_q[addr];

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: EX/MEM and MEM/WB registers around a fixed-latency data RAM.
// Memops take MEM_LATENCY cycles (others 1); mem_stall holds upstream and bubbles MEM/WB.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int MEM_LATENCY = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [1:0]  ex_wb,
    input  logic [2:0]  ex_m,
    input  logic [31:0] ex_aluout,
    input  logic [31:0] ex_writedata,
    input  logic [4:0]  ex_regdst,
    output logic [31:0] exmem_aluout,
    output logic [4:0]  exmem_regrd,
    output logic [1:0]  exmem_regwrite,
    output logic        exmem_memread,
    output logic [4:0]  memwb_regrd,
    output logic [1:0]  memwb_regwrite,
    output logic [31:0] wb_datatowrite,
    output logic        mem_stall
);

    localparam int ADDR_W = $clog2(DEPTH_WORDS);
    localparam int CNT_W  = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LATENCY - 1);

    logic [WB_W-1:0] exmem_wb_q,     exmem_wb_d;
    logic [M_W-1:0]  exmem_m_q,      exmem_m_d;
    logic [31:0]     exmem_aluout_q, exmem_aluout_d;
    logic [31:0]     exmem_wdata_q,  exmem_wdata_d;
    logic [4:0]      exmem_regrd_q,  exmem_regrd_d;

    logic [WB_W-1:0] memwb_wb_q,     memwb_wb_d;
    logic [4:0]      memwb_regrd_q,  memwb_regrd_d;
    logic [31:0]     memwb_aluout_q, memwb_aluout_d;
    logic [31:0]     memwb_rdata_q,  memwb_rdata_d;

    mem_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;

    logic              memop;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_rdata;
    logic              unused_branch;

    assign memop     = is_memop(exmem_m_q);
    assign mem_stall = memop & (cnt_q != CNT_LAST);
    assign ram_addr  = exmem_aluout_q[ADDR_W+1:2];
    // Commit only on the final cycle so a store lands exactly once, before the next access.
    assign ram_we    = exmem_m_q[M_MEMWRITE] & ~mem_stall;

    assign unused_branch = exmem_m_q[M_BRANCH];

    data_ram #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .ADDR_W     (ADDR_W)
    ) u_data_ram (
        .clock(clock),
        .we   (ram_we),
        .addr (ram_addr),
        .wdata(exmem_wdata_q),
        .rdata(ram_rdata)
    );

    always_comb begin
        exmem_wb_d     = exmem_wb_q;
        exmem_m_d      = exmem_m_q;
        exmem_aluout_d = exmem_aluout_q;
        exmem_wdata_d  = exmem_wdata_q;
        exmem_regrd_d  = exmem_regrd_q;
        memwb_wb_d     = '0;
        memwb_regrd_d  = '0;
        memwb_aluout_d = '0;
        memwb_rdata_d  = '0;
        if (!mem_stall) begin
            exmem_wb_d     = ex_wb;
            exmem_m_d      = ex_m;
            exmem_aluout_d = ex_aluout;
            exmem_wdata_d  = ex_writedata;
            exmem_regrd_d  = ex_regdst;
            memwb_wb_d     = exmem_wb_q;
            memwb_regrd_d  = exmem_regrd_q;
            memwb_aluout_d = exmem_aluout_q;
            memwb_rdata_d  = is_load(exmem_m_q) ? ram_rdata : 32'h0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            exmem_wb_q     <= '0;
            exmem_m_q      <= '0;
            exmem_aluout_q <= '0;
            exmem_wdata_q  <= '0;
            exmem_regrd_q  <= '0;
            memwb_wb_q     <= '0;
            memwb_regrd_q  <= '0;
            memwb_aluout_q <= '0;
            memwb_rdata_q  <= '0;
        end else begin
            exmem_wb_q     <= exmem_wb_d;
            exmem_m_q      <= exmem_m_d;
            exmem_aluout_q <= exmem_aluout_d;
            exmem_wdata_q  <= exmem_wdata_d;
            exmem_regrd_q  <= exmem_regrd_d;
            memwb_wb_q     <= memwb_wb_d;
            memwb_regrd_q  <= memwb_regrd_d;
            memwb_aluout_q <= memwb_aluout_d;
            memwb_rdata_q  <= memwb_rdata_d;
        end
    end

    // cnt_q counts cycles already spent on the access held in EX/MEM.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (memop && (MEM_LATENCY > 1)) begin
                        state_q <= ST_BUSY;
                        cnt_q   <= CNT_W'(1);
                    end
                end
                ST_BUSY: begin
                    if (cnt_q == CNT_LAST) begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign exmem_aluout   = exmem_aluout_q;
    assign exmem_regrd    = exmem_regrd_q;
    assign exmem_regwrite = exmem_wb_q;
    assign exmem_memread  = exmem_m_q[M_MEMREAD];
    assign memwb_regrd    = memwb_regrd_q;
    assign memwb_regwrite = memwb_wb_q;
    assign wb_datatowrite = memwb_wb_q[WB_MEMTOREG] ? memwb_rdata_q : memwb_aluout_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: four instances with MEM_LATENCY 1..4 share stimulus;
// each scenario observes the instance selected by sel.
module tb_mem_stage;

    logic        clock;
    logic        reset_n;
    logic [1:0]  ex_wb;
    logic [2:0]  ex_m;
    logic [31:0] ex_aluout;
    logic [31:0] ex_writedata;
    logic [4:0]  ex_regdst;

    logic [31:0] o_exmem_aluout [1:4];
    logic [4:0]  o_exmem_regrd  [1:4];
    logic [1:0]  o_exmem_wb     [1:4];
    logic        o_exmem_rd     [1:4];
    logic [4:0]  o_memwb_regrd  [1:4];
    logic [1:0]  o_memwb_wb     [1:4];
    logic [31:0] o_wb_data      [1:4];
    logic        o_stall        [1:4];

    int sel;
    int n_vec;
    int n_err;

    for (genvar g = 1; g <= 4; g++) begin : g_dut
        mem_stage #(
            .DEPTH_WORDS(256),
            .MEM_LATENCY(g)
        ) u_dut (
            .clock         (clock),
            .reset_n       (reset_n),
            .ex_wb         (ex_wb),
            .ex_m          (ex_m),
            .ex_aluout     (ex_aluout),
            .ex_writedata  (ex_writedata),
            .ex_regdst     (ex_regdst),
            .exmem_aluout  (o_exmem_aluout[g]),
            .exmem_regrd   (o_exmem_regrd[g]),
            .exmem_regwrite(o_exmem_wb[g]),
            .exmem_memread (o_exmem_rd[g]),
            .memwb_regrd   (o_memwb_regrd[g]),
            .memwb_regwrite(o_memwb_wb[g]),
            .wb_datatowrite(o_wb_data[g]),
            .mem_stall     (o_stall[g])
        );
    end

    logic [31:0] cur_exmem_aluout;
    logic [4:0]  cur_exmem_regrd;
    logic [1:0]  cur_exmem_wb;
    logic        cur_exmem_rd;
    logic [4:0]  cur_memwb_regrd;
    logic [1:0]  cur_memwb_wb;
    logic [31:0] cur_wb_data;
    logic        cur_stall;

    assign cur_exmem_aluout = o_exmem_aluout[sel];
    assign cur_exmem_regrd  = o_exmem_regrd[sel];
    assign cur_exmem_wb     = o_exmem_wb[sel];
    assign cur_exmem_rd     = o_exmem_rd[sel];
    assign cur_memwb_regrd  = o_memwb_regrd[sel];
    assign cur_memwb_wb     = o_memwb_wb[sel];
    assign cur_wb_data      = o_wb_data[sel];
    assign cur_stall        = o_stall[sel];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic drive(input logic [1:0] wb, input logic [2:0] m, input logic [31:0] alu,
                         input logic [31:0] wd, input logic [4:0] rd);
        ex_wb        = wb;
        ex_m         = m;
        ex_aluout    = alu;
        ex_writedata = wd;
        ex_regdst    = rd;
    endtask

    // Presents one instruction, then nops; returns once it sits in MEM/WB.
    task automatic issue(input logic [1:0] wb, input logic [2:0] m, input logic [31:0] alu,
                         input logic [31:0] wd, input logic [4:0] rd,
                         output int stalls, output int edges);
        stalls = 0;
        edges  = 0;
        drive(wb, m, alu, wd, rd);
        @(negedge clock); edges++;
        drive(2'b00, 3'b000, 32'h0, 32'h0, 5'd0);
        while (cur_stall === 1'b1 && stalls < 16) begin
            stalls++;
            @(negedge clock); edges++;
        end
        @(negedge clock); edges++;
    endtask

    task automatic test_reset;
        sel = 2;
        reset_n = 1'b0;
        drive(2'b00, 3'b000, 32'h0, 32'h0, 5'd0);
        #2;
        n_vec++; if (cur_exmem_aluout !== 32'h0) begin n_err++; $display("FAIL rst_exmem_aluout got=%h exp=0", cur_exmem_aluout); end
        n_vec++; if ({cur_exmem_regrd, cur_exmem_wb, cur_exmem_rd} !== 8'h0) begin n_err++; $display("FAIL rst_exmem_ctl got=%h exp=0", {cur_exmem_regrd, cur_exmem_wb, cur_exmem_rd}); end
        n_vec++; if ({cur_memwb_regrd, cur_memwb_wb} !== 7'h0) begin n_err++; $display("FAIL rst_memwb_ctl got=%h exp=0", {cur_memwb_regrd, cur_memwb_wb}); end
        n_vec++; if (cur_wb_data !== 32'h0) begin n_err++; $display("FAIL rst_wb_data got=%h exp=0", cur_wb_data); end
        n_vec++; if (cur_stall !== 1'b0) begin n_err++; $display("FAIL rst_stall got=%b exp=0", cur_stall); end
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        n_vec++; if (cur_wb_data !== 32'h0) begin n_err++; $display("FAIL rst_after_wb_data got=%h exp=0", cur_wb_data); end
    endtask

    task automatic test_alu_op;
        sel = 2;
        drive(2'b01, 3'b000, 32'h1234, 32'h0, 5'd5);
        @(negedge clock);
        drive(2'b00, 3'b000, 32'h0, 32'h0, 5'd0);
        n_vec++; if (cur_exmem_regrd !== 5'd5) begin n_err++; $display("FAIL alu_exmem_regrd got=%0d exp=5", cur_exmem_regrd); end
        n_vec++; if (cur_exmem_aluout !== 32'h1234) begin n_err++; $display("FAIL alu_exmem_aluout got=%h exp=1234", cur_exmem_aluout); end
        n_vec++; if (cur_exmem_wb !== 2'b01) begin n_err++; $display("FAIL alu_exmem_wb got=%b exp=01", cur_exmem_wb); end
        n_vec++; if (cur_stall !== 1'b0) begin n_err++; $display("FAIL alu_stall1 got=%b exp=0", cur_stall); end
        @(negedge clock);
        n_vec++; if (cur_memwb_regrd !== 5'd5) begin n_err++; $display("FAIL alu_memwb_regrd got=%0d exp=5", cur_memwb_regrd); end
        n_vec++; if (cur_wb_data !== 32'h1234) begin n_err++; $display("FAIL alu_wb_data got=%h exp=1234", cur_wb_data); end
        n_vec++; if (cur_memwb_wb !== 2'b01) begin n_err++; $display("FAIL alu_memwb_wb got=%b exp=01", cur_memwb_wb); end
        n_vec++; if (cur_stall !== 1'b0) begin n_err++; $display("FAIL alu_stall2 got=%b exp=0", cur_stall); end
    endtask

    task automatic test_store_load;
        sel = 2;
        drive(2'b00, 3'b001, 32'h10, 32'hDEADBEEF, 5'd0);
        @(negedge clock);
        n_vec++; if (cur_stall !== 1'b1) begin n_err++; $display("FAIL st_stall_first got=%b exp=1", cur_stall); end
        drive(2'b11, 3'b010, 32'h10, 32'h0, 5'd7);
        @(negedge clock);
        n_vec++; if (cur_stall !== 1'b0) begin n_err++; $display("FAIL st_stall_final got=%b exp=0", cur_stall); end
        n_vec++; if ({cur_memwb_wb, cur_memwb_regrd} !== 7'h0) begin n_err++; $display("FAIL st_bubble got=%h exp=0", {cur_memwb_wb, cur_memwb_regrd}); end
        @(negedge clock);
        drive(2'b00, 3'b000, 32'h0, 32'h0, 5'd0);
        n_vec++; if (cur_stall !== 1'b1) begin n_err++; $display("FAIL ld_stall_first got=%b exp=1", cur_stall); end
        n_vec++; if (cur_exmem_rd !== 1'b1) begin n_err++; $display("FAIL ld_exmem_memread got=%b exp=1", cur_exmem_rd); end
        @(negedge clock);
        n_vec++; if (cur_stall !== 1'b0) begin n_err++; $display("FAIL ld_stall_final got=%b exp=0", cur_stall); end
        n_vec++; if (cur_memwb_wb !== 2'b00) begin n_err++; $display("FAIL ld_bubble got=%b exp=00", cur_memwb_wb); end
        @(negedge clock);
        n_vec++; if (cur_wb_data !== 32'hDEADBEEF) begin n_err++; $display("FAIL ld_wb_data got=%h exp=deadbeef", cur_wb_data); end
        n_vec++; if (cur_memwb_wb !== 2'b11) begin n_err++; $display("FAIL ld_memwb_wb got=%b exp=11", cur_memwb_wb); end
        n_vec++; if (cur_memwb_regrd !== 5'd7) begin n_err++; $display("FAIL ld_memwb_regrd got=%0d exp=7", cur_memwb_regrd); end
    endtask

    task automatic test_wrap;
        int stalls;
        int edges;
        sel = 2;
        issue(2'b00, 3'b001, 32'h13, 32'h55, 5'd0, stalls, edges);
        n_vec++; if (stalls != 1) begin n_err++; $display("FAIL wrap_st_stalls got=%0d exp=1", stalls); end
        issue(2'b11, 3'b010, 32'h10, 32'h0, 5'd8, stalls, edges);
        n_vec++; if (cur_wb_data !== 32'h55) begin n_err++; $display("FAIL wrap_ld10 got=%h exp=55", cur_wb_data); end
        n_vec++; if (edges != 3) begin n_err++; $display("FAIL wrap_ld10_edges got=%0d exp=3", edges); end
        issue(2'b11, 3'b010, 32'h410, 32'h0, 5'd9, stalls, edges);
        n_vec++; if (cur_wb_data !== 32'h55) begin n_err++; $display("FAIL wrap_ld410 got=%h exp=55", cur_wb_data); end
        n_vec++; if (cur_memwb_regrd !== 5'd9) begin n_err++; $display("FAIL wrap_ld410_regrd got=%0d exp=9", cur_memwb_regrd); end
    endtask

    task automatic test_back_to_back;
        sel = 1;
        drive(2'b00, 3'b001, 32'h20, 32'h11111111, 5'd0);
        @(negedge clock);
        n_vec++; if (cur_stall !== 1'b0) begin n_err++; $display("FAIL b2b_stall1 got=%b exp=0", cur_stall); end
        drive(2'b11, 3'b010, 32'h20, 32'h0, 5'd3);
        @(negedge clock);
        n_vec++; if (cur_stall !== 1'b0) begin n_err++; $display("FAIL b2b_stall2 got=%b exp=0", cur_stall); end
        n_vec++; if (cur_memwb_wb !== 2'b00) begin n_err++; $display("FAIL b2b_st_memwb got=%b exp=00", cur_memwb_wb); end
        drive(2'b00, 3'b001, 32'h24, 32'h22222222, 5'd0);
        @(negedge clock);
        n_vec++; if (cur_stall !== 1'b0) begin n_err++; $display("FAIL b2b_stall3 got=%b exp=0", cur_stall); end
        n_vec++; if (cur_wb_data !== 32'h11111111) begin n_err++; $display("FAIL b2b_ld1 got=%h exp=11111111", cur_wb_data); end
        n_vec++; if (cur_memwb_regrd !== 5'd3) begin n_err++; $display("FAIL b2b_ld1_regrd got=%0d exp=3", cur_memwb_regrd); end
        drive(2'b11, 3'b010, 32'h24, 32'h0, 5'd4);
        @(negedge clock);
        n_vec++; if (cur_stall !== 1'b0) begin n_err++; $display("FAIL b2b_stall4 got=%b exp=0", cur_stall); end
        drive(2'b00, 3'b000, 32'h0, 32'h0, 5'd0);
        @(negedge clock);
        n_vec++; if (cur_wb_data !== 32'h22222222) begin n_err++; $display("FAIL b2b_ld2 got=%h exp=22222222", cur_wb_data); end
        n_vec++; if (cur_memwb_wb !== 2'b11) begin n_err++; $display("FAIL b2b_ld2_wb got=%b exp=11", cur_memwb_wb); end
    endtask

    task automatic test_stall_hold;
        int stalls;
        int edges;
        sel = 4;
        issue(2'b00, 3'b001, 32'h30, 32'hCAFEF00D, 5'd0, stalls, edges);
        n_vec++; if (stalls != 3) begin n_err++; $display("FAIL hold_st_stalls got=%0d exp=3", stalls); end
        drive(2'b11, 3'b010, 32'h30, 32'h0, 5'd10);
        @(negedge clock);
        drive(2'b01, 3'b000, 32'h777, 32'h0, 5'd11);
        for (int c = 0; c < 3; c++) begin
            n_vec++; if (cur_stall !== 1'b1) begin n_err++; $display("FAIL hold_stall[%0d] got=%b exp=1", c, cur_stall); end
            n_vec++; if ({cur_exmem_regrd, cur_exmem_aluout} !== {5'd10, 32'h30}) begin n_err++; $display("FAIL hold_exmem[%0d] got=%0d/%h exp=10/30", c, cur_exmem_regrd, cur_exmem_aluout); end
            @(negedge clock);
            n_vec++; if (cur_memwb_wb !== 2'b00) begin n_err++; $display("FAIL hold_bubble[%0d] got=%b exp=00", c, cur_memwb_wb); end
        end
        n_vec++; if (cur_stall !== 1'b0) begin n_err++; $display("FAIL hold_final_stall got=%b exp=0", cur_stall); end
        @(negedge clock);
        drive(2'b00, 3'b000, 32'h0, 32'h0, 5'd0);
        n_vec++; if ({cur_exmem_regrd, cur_exmem_aluout} !== {5'd11, 32'h777}) begin n_err++; $display("FAIL hold_alu_enter got=%0d/%h exp=11/777", cur_exmem_regrd, cur_exmem_aluout); end
        n_vec++; if (cur_wb_data !== 32'hCAFEF00D) begin n_err++; $display("FAIL hold_ld_data got=%h exp=cafef00d", cur_wb_data); end
        n_vec++; if (cur_memwb_regrd !== 5'd10) begin n_err++; $display("FAIL hold_ld_regrd got=%0d exp=10", cur_memwb_regrd); end
        @(negedge clock);
        n_vec++; if (cur_wb_data !== 32'h777) begin n_err++; $display("FAIL hold_alu_wb got=%h exp=777", cur_wb_data); end
    endtask

    task automatic test_reset_midstore;
        int stalls;
        int edges;
        sel = 3;
        issue(2'b00, 3'b001, 32'h40, 32'hAAAA0001, 5'd0, stalls, edges);
        n_vec++; if (stalls != 2) begin n_err++; $display("FAIL mid_st_stalls got=%0d exp=2", stalls); end
        drive(2'b00, 3'b001, 32'h40, 32'hBBBB0002, 5'd0);
        @(negedge clock);
        drive(2'b00, 3'b000, 32'h0, 32'h0, 5'd0);
        @(negedge clock);
        n_vec++; if (cur_stall !== 1'b1) begin n_err++; $display("FAIL mid_busy_stall got=%b exp=1", cur_stall); end
        reset_n = 1'b0;
        #1;
        n_vec++; if (cur_stall !== 1'b0) begin n_err++; $display("FAIL mid_rst_stall got=%b exp=0", cur_stall); end
        n_vec++; if (cur_exmem_aluout !== 32'h0) begin n_err++; $display("FAIL mid_rst_exmem got=%h exp=0", cur_exmem_aluout); end
        n_vec++; if ({cur_exmem_rd, cur_memwb_wb, cur_memwb_regrd} !== 8'h0) begin n_err++; $display("FAIL mid_rst_ctl got=%h exp=0", {cur_exmem_rd, cur_memwb_wb, cur_memwb_regrd}); end
        @(negedge clock);
        reset_n = 1'b1;
        issue(2'b11, 3'b010, 32'h40, 32'h0, 5'd12, stalls, edges);
        n_vec++; if (cur_wb_data !== 32'hAAAA0001) begin n_err++; $display("FAIL mid_old_data got=%h exp=aaaa0001", cur_wb_data); end
        n_vec++; if (edges != 4) begin n_err++; $display("FAIL mid_ld_edges got=%0d exp=4", edges); end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        sel   = 2;
        test_reset();
        test_alu_op();
        test_store_load();
        test_wrap();
        test_back_to_back();
        test_stall_hold();
        test_reset_midstore();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage directly downstream of the execute stage.
- Registers the execute stage's results in the EX/MEM pipeline register and performs data-memory loads/stores against an internal word-addressed RAM with configurable access latency.
- Produces the MEM/WB register contents and the write-back data.
- Supplies the forwarding sources (EX/MEM and MEM/WB destination register, RegWrite and data) consumed by the execute stage, and a stall that freezes upstream stages during multi-cycle accesses.

Parameters:
DEPTH_WORDS, 256, data memory depth in 32-bit words (power of 2); ADDR_W = log2(DEPTH_WORDS)
MEM_LATENCY, 2, cycles a load/store occupies the stage (>=1); 1 = no stall

Ports:
clock  input  1  rising-edge clock
reset_n  input  1  asynchronous, active-low reset
ex_wb  input  2  WB control from execute: [0] RegWrite, [1] MemtoReg
ex_m  input  3  MEM control: [2] Branch (carried, unused), [1] MemRead, [0] MemWrite
ex_aluout  input  32  ALU result / memory byte address
ex_writedata  input  32  store data
ex_regdst  input  5  destination register selected by execute
exmem_aluout  output  32  EX/MEM ALU result (forwarding source)
exmem_regrd  output  5  EX/MEM destination register
exmem_regwrite  output  2  EX/MEM WB control (bit 0 = RegWrite)
exmem_memread  output  1  EX/MEM MemRead (for load-use detection)
memwb_regrd  output  5  MEM/WB destination register
memwb_regwrite  output  2  MEM/WB WB control
wb_datatowrite  output  32  write-back data: MemtoReg ? memwb_readdata : memwb_aluout
mem_stall  output  1  upstream must hold IF/ID/EX registers this cycle

Behaviour:
Reset:
- Asynchronous on reset_n low: all EX/MEM and MEM/WB fields 0, FSM IDLE, counter 0.
- All outputs read 0 during and after reset.
- RAM contents are not reset.
EX/MEM register:
- Captures ex_* on each rising edge when mem_stall=0; holds when mem_stall=1.
memop:
- memop = exmem MemRead | MemWrite.
- Both set: treated as a write only; no read data is produced.
Word address:
- exmem_aluout[ADDR_W+1:2]; bits [1:0] ignored.
- Upper bits are ignored, so addresses wrap modulo DEPTH_WORDS.
FSM states:
- IDLE (cnt=0) and BUSY; counter width ceil(log2(MEM_LATENCY)) bits, minimum 1.
- mem_stall = memop & (cnt != MEM_LATENCY-1), combinational.
FSM transitions:
- IDLE, memop, MEM_LATENCY>1 -> BUSY, cnt<=1.
- BUSY, cnt<MEM_LATENCY-1 -> cnt<=cnt+1.
- The cycle with cnt==MEM_LATENCY-1 is the final cycle: stall low, -> IDLE, cnt<=0.
- With MEM_LATENCY=1 the FSM never leaves IDLE and mem_stall is never asserted.
Final cycle (mem_stall low):
- Store writes RAM exactly once on this edge.
- Load data is read combinationally from RAM and captured into MEM/WB on this edge.
- Non-memory instructions are always final in their first cycle.
MEM/WB register:
- Advance edges (mem_stall=0): captures wb, regdst, aluout, readdata.
- Stall edges: captures a bubble (wb=00, regrd=0), so no duplicate write-back or forwarding.
- memwb_readdata = 0 for non-loads.
Latency:
- ex_* -> exmem_* : 1 edge.
- exmem_* -> memwb_* / wb_datatowrite : MEM_LATENCY edges for memops, 1 otherwise.
Back-to-back memops:
- The next memop entering EX/MEM on the final edge starts fresh at cnt=0 in IDLE.
Load-then-read:
- A load of an address stored by the immediately preceding instruction returns the new data, because the write commits before the next access begins.
Reset mid-access:
- Aborts; a pending store is not committed; FSM returns to IDLE.

Decomposition:
- Shared package: WB/M control bit indices (WB_REGWRITE=0, WB_MEMTOREG=1, M_MEMWRITE=0, M_MEMREAD=1, M_BRANCH=2) and the FSM state enum.
- One sub-module, data_ram: DEPTH_WORDS x 32 array, synchronous write, combinational read, ports clock, we, addr, wdata, rdata.
- Pipeline registers and FSM stay in mem_stage.

Test Plan:
1. Reset: assert reset_n=0 mid-store (MEM_LATENCY=3, cnt=1) -> all outputs 0 immediately; after release, read of that address returns its pre-store value.
2. ALU op, no memop: ex_wb=01, ex_regdst=5, ex_aluout=0x1234 -> next edge exmem_regrd=5, exmem_aluout=0x1234; following edge memwb_regrd=5, wb_datatowrite=0x1234; mem_stall stays 0.
3. Store/load, MEM_LATENCY=2:
   - store 0xDEADBEEF to addr 0x10 -> mem_stall high exactly 1 cycle, MEM/WB gets a bubble.
   - load (ex_wb=11) from 0x10 -> mem_stall 1 cycle, then wb_datatowrite=0xDEADBEEF, memwb_regwrite=11.
4. Wrap and misalignment, DEPTH_WORDS=256: store 0x55 to 0x13 (word 4) -> loads from 0x10 and 0x410 both return 0x55.
5. MEM_LATENCY=1: alternating store/load stream of 4 instructions -> mem_stall never asserted; each result appears 2 edges after entry.
6. Stall hold, MEM_LATENCY=4: load followed by ALU op held at inputs -> mem_stall high 3 cycles; exmem_* stable throughout; MEM/WB bubbles for 3 edges; ALU op enters EX/MEM on the 4th edge.
